// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution: condition evaluation, target/mispredict check,
// registered redirect and a predictor-update FIFO. Optional perf counters: BR_PERF_CNT_EN.
module ex_branch_resolve #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          pc,
  input  logic [3:0]               cond,
  input  logic                     cmt,
  input  logic [XLEN-1:0]          imm,
  input  logic [XLEN-1:0]          sr1,
  input  logic [XLEN-1:0]          sr2,
  input  logic                     pred_taken,
  input  logic [XLEN-1:0]          pred_pc,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic                     dir_fail,
  output logic                     addr_fail,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [XLEN-1:0]          upd_pc,
  output logic [XLEN-1:0]          upd_tpc,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   upd_count,
  output logic [CNT_W-1:0]         perf_br_cnt,
  output logic [CNT_W-1:0]         perf_miss_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] C_JIRL = 4'd3;
  localparam logic [3:0] C_B    = 4'd4;
  localparam logic [3:0] C_BL   = 4'd5;
  localparam logic [3:0] C_BEQ  = 4'd6;
  localparam logic [3:0] C_BNE  = 4'd7;
  localparam logic [3:0] C_BLT  = 4'd8;
  localparam logic [3:0] C_BGE  = 4'd9;
  localparam logic [3:0] C_BLTU = 4'd10;
  localparam logic [3:0] C_BGEU = 4'd11;

  logic            acc, is_br, eq, lt, ltu, cond_hit, taken, d_fail, a_fail;
  logic            push, pop;
  logic [XLEN-1:0] imm_sh, target, fall_pc, real_pc;

  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_tpc   [DEPTH];
  logic            mem_taken [DEPTH];

  assign in_ready  = (count_reg != CW'(DEPTH));
  assign upd_valid = (count_reg != '0);
  assign upd_count = count_reg;
  assign acc       = in_valid & in_ready & ~flush;

  assign eq     = (sr1 == sr2);
  assign ltu    = (sr1 < sr2);
  assign lt     = ($signed(sr1) < $signed(sr2));
  assign is_br  = (cond >= C_JIRL) && (cond <= C_BGEU);
  assign imm_sh = imm << 2;

  always_comb begin
    cond_hit = 1'b0;
    case (cond)
      C_JIRL, C_B, C_BL: cond_hit = 1'b1;
      C_BEQ:             cond_hit = eq;
      C_BNE:             cond_hit = ~eq;
      C_BLT:             cond_hit = lt;
      C_BGE:             cond_hit = ~lt;
      C_BLTU:            cond_hit = ltu;
      C_BGEU:            cond_hit = ~ltu;
      default:           cond_hit = 1'b0;
    endcase
  end

  assign taken   = is_br & cond_hit;
  assign target  = ((cond == C_JIRL) ? sr1 : pc) + imm_sh;
  assign fall_pc = pc + (cmt ? XLEN'(4) : XLEN'(8));
  assign real_pc = taken ? target : fall_pc;

  // A correct direction on a taken branch can still miss on the predicted target.
  assign d_fail = taken ^ pred_taken;
  assign a_fail = d_fail | (taken & pred_taken & (pred_pc != target));

  assign push = acc & is_br;
  assign pop  = upd_valid & upd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      dir_fail       <= 1'b0;
      addr_fail      <= 1'b0;
    end else if (acc) begin
      redirect_valid <= a_fail;
      redirect_pc    <= real_pc;
      dir_fail       <= d_fail;
      addr_fail      <= a_fail;
    end else begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      dir_fail       <= 1'b0;
      addr_fail      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage carries no reset; contents are only observed while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_reg]    <= pc;
      mem_tpc[wr_ptr_reg]   <= real_pc;
      mem_taken[wr_ptr_reg] <= taken;
    end
  end

  assign upd_pc    = upd_valid ? mem_pc[rd_ptr_reg]    : '0;
  assign upd_tpc   = upd_valid ? mem_tpc[rd_ptr_reg]   : '0;
  assign upd_taken = upd_valid ? mem_taken[rd_ptr_reg] : 1'b0;

`ifdef BR_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_reg   <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (push && (br_cnt_reg != '1))
        br_cnt_reg <= br_cnt_reg + CNT_W'(1);
      if (acc && a_fail && (miss_cnt_reg != '1))
        miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
    end
  end

  assign perf_br_cnt   = br_cnt_reg;
  assign perf_miss_cnt = miss_cnt_reg;
`else
  assign perf_br_cnt   = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Bench for ex_branch_resolve: vector table plus full/flush/reset sequences,
// with a queue model of the stage output and the predictor-update FIFO.
module tb_ex_branch_resolve;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, cmt, pred_taken;
  logic [3:0]        cond;
  logic [XLEN-1:0]   pc, imm, sr1, sr2, pred_pc;
  logic              redirect_valid, dir_fail, addr_fail;
  logic [XLEN-1:0]   redirect_pc;
  logic              upd_valid, upd_ready, upd_taken;
  logic [XLEN-1:0]   upd_pc, upd_tpc;
  logic [$clog2(DEPTH):0] upd_count;
  logic [CNT_W-1:0]  perf_br_cnt, perf_miss_cnt;

  ex_branch_resolve #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .cond(cond), .cmt(cmt), .imm(imm), .sr1(sr1), .sr2(sr2),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dir_fail(dir_fail), .addr_fail(addr_fail),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_tpc(upd_tpc), .upd_taken(upd_taken), .upd_count(upd_count),
    .perf_br_cnt(perf_br_cnt), .perf_miss_cnt(perf_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic        cmt;
    logic [31:0] pc, imm, sr1, sr2;
    logic        pt;
    logic [31:0] ppc;
    logic        e_rv, e_df, e_af;
    logic [31:0] e_rpc;
    logic        e_push, e_taken;
  } vec_t;

  typedef struct { logic rv, df, af; logic [31:0] rpc; } stage_t;
  typedef struct { logic [31:0] pc, tpc; logic taken; } ent_t;

  vec_t   tbl [13];
  vec_t   idle;
  stage_t stage_q [$];
  ent_t   fifo_q  [$];
  int     checks = 0;
  int     failures = 0;
  int     exp_br = 0;
  int     exp_miss = 0;

  function automatic vec_t mk(input logic [3:0] c, input logic cm, input logic [31:0] p,
                              input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                              input logic pt, input logic [31:0] ppc,
                              input logic rv, input logic df, input logic af,
                              input logic [31:0] rpc, input logic ps, input logic tk);
    vec_t v;
    v.cond = c; v.cmt = cm; v.pc = p; v.imm = im; v.sr1 = a; v.sr2 = b;
    v.pt = pt; v.ppc = ppc; v.e_rv = rv; v.e_df = df; v.e_af = af;
    v.e_rpc = rpc; v.e_push = ps; v.e_taken = tk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive, pop-compare FIFO head if handshake, then check stage outputs.
  task automatic cycle(input logic iv, input logic fl, input vec_t v);
    stage_t s;
    ent_t   h;
    logic   acc_e;
    in_valid = iv; flush = fl; cond = v.cond; cmt = v.cmt; pc = v.pc; imm = v.imm;
    sr1 = v.sr1; sr2 = v.sr2; pred_taken = v.pt; pred_pc = v.ppc;
    #1;
    chk("in_ready", in_ready, fifo_q.size() < DEPTH);
    acc_e = iv && !fl && (fifo_q.size() < DEPTH);
    s.rv = acc_e ? v.e_rv : 1'b0;
    s.df = acc_e ? v.e_df : 1'b0;
    s.af = acc_e ? v.e_af : 1'b0;
    s.rpc = acc_e ? v.e_rpc : 32'h0;
    stage_q.push_back(s);
    if (upd_valid && upd_ready) begin
      if (fifo_q.size() == 0) begin
        chk("pop_on_empty", 1, 0);
      end else begin
        h = fifo_q.pop_front();
        chk("upd_pc", upd_pc, h.pc);
        chk("upd_tpc", upd_tpc, h.tpc);
        chk("upd_taken", upd_taken, h.taken);
      end
    end
    @(posedge clk); #1;
    if (acc_e && v.e_push) begin
      h.pc = v.pc; h.tpc = v.e_rpc; h.taken = v.e_taken;
      fifo_q.push_back(h);
      exp_br++;
    end
    if (acc_e && v.e_rv) exp_miss++;
    s = stage_q.pop_front();
    $display("cyc pc=%h cond=%0d iv=%0b fl=%0b rv=%0b df=%0b af=%0b rpc=%h cnt=%0d",
             v.pc, v.cond, iv, fl, redirect_valid, dir_fail, addr_fail, redirect_pc, upd_count);
    chk("redirect_valid", redirect_valid, s.rv);
    chk("dir_fail", dir_fail, s.df);
    chk("addr_fail", addr_fail, s.af);
    chk("redirect_pc", redirect_pc, s.rpc);
    chk("upd_count", upd_count, fifo_q.size());
    chk("upd_valid", upd_valid, fifo_q.size() != 0);
`ifdef BR_PERF_CNT_EN
    chk("perf_br_cnt", perf_br_cnt, exp_br);
    chk("perf_miss_cnt", perf_miss_cnt, exp_miss);
`else
    chk("perf_br_cnt", perf_br_cnt, 0);
    chk("perf_miss_cnt", perf_miss_cnt, 0);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_dir_fail"}, dir_fail, 0);
    chk({tag, "_addr_fail"}, addr_fail, 0);
    chk({tag, "_upd_valid"}, upd_valid, 0);
    chk({tag, "_upd_count"}, upd_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_perf_br"}, perf_br_cnt, 0);
    chk({tag, "_perf_miss"}, perf_miss_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //        cond  cmt pc            imm           sr1           sr2  pt ppc           rv df af rpc           push taken
    tbl[0]  = mk(4'd6,  1, 32'h1000,     32'h10,       32'h5,        32'h5, 1, 32'h1040, 0, 0, 0, 32'h1040, 1, 1);
    tbl[1]  = mk(4'd8,  0, 32'h1100,     32'h8,        32'hFFFFFFFF, 32'h1, 0, 32'h0,    1, 1, 1, 32'h1120, 1, 1);
    tbl[2]  = mk(4'd10, 0, 32'h1200,     32'h8,        32'hFFFFFFFF, 32'h1, 0, 32'h0,    0, 0, 0, 32'h1208, 1, 0);
    tbl[3]  = mk(4'd3,  1, 32'h1300,     32'h3,        32'h2000,     32'h0, 1, 32'h2000, 1, 0, 1, 32'h200C, 1, 1);
    tbl[4]  = mk(4'd0,  0, 32'h3000,     32'h0,        32'h0,        32'h0, 1, 32'h5555, 1, 1, 1, 32'h3008, 0, 0);
    tbl[5]  = mk(4'd7,  1, 32'h1400,     32'hFFFFFFFC, 32'h1,        32'h2, 1, 32'h13F0, 0, 0, 0, 32'h13F0, 1, 1);
    tbl[6]  = mk(4'd9,  1, 32'h1500,     32'h4,        32'hFFFFFFFF, 32'h1, 1, 32'h1510, 1, 1, 1, 32'h1504, 1, 0);
    tbl[7]  = mk(4'd11, 1, 32'h1600,     32'h4,        32'hFFFFFFFF, 32'h1, 0, 32'h0,    1, 1, 1, 32'h1610, 1, 1);
    tbl[8]  = mk(4'd4,  1, 32'hFFFFFFF0, 32'h8,        32'h0,        32'h0, 1, 32'h10,   0, 0, 0, 32'h10,   1, 1);
    tbl[9]  = mk(4'd5,  1, 32'h1700,     32'h1,        32'h0,        32'h0, 1, 32'h1708, 1, 0, 1, 32'h1704, 1, 1);
    tbl[10] = mk(4'd12, 1, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0);
    tbl[11] = mk(4'd6,  0, 32'h1800,     32'h10,       32'h5,        32'h6, 0, 32'h0,    0, 0, 0, 32'h1808, 1, 0);
    tbl[12] = mk(4'd2,  0, 32'h1900,     32'h0,        32'h0,        32'h0, 0, 32'h0,    0, 0, 0, 32'h1908, 0, 0);
    idle    = mk(4'd0,  1, 32'h0,        32'h0,        32'h0,        32'h0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; upd_ready = 1'b0;
    cond = '0; cmt = 1'b0; pc = '0; imm = '0; sr1 = '0; sr2 = '0;
    pred_taken = 1'b0; pred_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Vector table, predictor always ready so entries drain as they arrive.
    upd_ready = 1'b1;
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, tbl[i]);
    cycle(1'b0, 1'b0, idle);
    cycle(1'b0, 1'b0, idle);

    // Fill to full with the predictor stalled, then a single pop.
    upd_ready = 1'b0;
    cycle(1'b1, 1'b0, tbl[0]);
    cycle(1'b1, 1'b0, tbl[1]);
    cycle(1'b1, 1'b0, tbl[2]);
    cycle(1'b1, 1'b0, tbl[5]);
    cycle(1'b1, 1'b0, tbl[3]);        // refused: full
    upd_ready = 1'b1;
    cycle(1'b1, 1'b0, tbl[7]);        // pop only; in_ready still low this cycle
    cycle(1'b1, 1'b0, tbl[8]);        // push concurrent with pop keeps occupancy
    cycle(1'b1, 1'b0, tbl[9]);
    upd_ready = 1'b0;
    cycle(1'b0, 1'b0, idle);

    // Flush with a mispredicting branch: nothing accepted, drain still proceeds.
    upd_ready = 1'b1;
    cycle(1'b1, 1'b1, tbl[1]);
    cycle(1'b1, 1'b1, tbl[4]);
    cycle(1'b1, 1'b0, tbl[6]);

    // Refill, then reset asynchronously while draining.
    upd_ready = 1'b0;
    cycle(1'b1, 1'b0, tbl[0]);
    cycle(1'b1, 1'b0, tbl[3]);
    upd_ready = 1'b1;
    cycle(1'b1, 1'b0, tbl[1]);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    fifo_q.delete();
    stage_q.delete();
    exp_br = 0;
    exp_miss = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, tbl[7]);
    cycle(1'b1, 1'b0, tbl[9]);
    cycle(1'b0, 1'b0, idle);
    cycle(1'b0, 1'b0, idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
